// File: rtl/instr_stream_encoder.sv
// Packs pnemonic instruction requests into 32-bit MIPS words and streams them to instruction memory.
// Latency: accept -> encode register -> FIFO head, so mem_we rises 2 cycles after acceptance at the earliest.
// Backpressure: req_ready drops when the encode register and the FIFO are both full; mem_ready stalls the FIFO head. Option: INSTR_ENC_ZEROREG_CHK_EN.

package mips_pkg;
    localparam logic [5:0] ZERO  = 6'h00;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] ADDIU = 6'h09;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] JUMP  = 6'h02;
    localparam logic [5:0] ABS   = 6'h1C;

    localparam logic [5:0] ADD   = 6'h20;
    localparam logic [5:0] AND   = 6'h24;
    localparam logic [5:0] OR    = 6'h25;
    localparam logic [5:0] SLT   = 6'h2A;
    localparam logic [5:0] SUB   = 6'h22;
    localparam logic [5:0] XOR   = 6'h26;
    localparam logic [5:0] SRA   = 6'h03;
    localparam logic [5:0] SRL   = 6'h02;
    localparam logic [5:0] SLL   = 6'h00;
    localparam logic [5:0] MULT  = 6'h18;

    typedef enum logic [4:0] {
        NEM_ZERO, NEM_ADD, NEM_AND, NEM_OR, NEM_SLT, NEM_SUB, NEM_XOR,
        NEM_SRA, NEM_SRL, NEM_SLL, NEM_MULT,
        NEM_ADDI, NEM_ADDIU, NEM_BEQ, NEM_LW, NEM_SW, NEM_JUMP, NEM_ABS,
        NEM_BNE, NEM_LUI, NEM_ORI
    } t_instr_pnmen;
endpackage

module isenc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(DEPTH));
endmodule

module instr_stream_encoder
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int MAX_WORDS  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic                         last,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  t_instr_pnmen                 req_pnem,
    input  logic [4:0]                   req_rs,
    input  logic [4:0]                   req_rt,
    input  logic [4:0]                   req_rd,
    input  logic [4:0]                   req_shamt,
    input  logic [15:0]                  req_imm,
    input  logic [25:0]                  req_target,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err_illegal,
    output logic [$clog2(MAX_WORDS):0]   word_count
);
    localparam int CNT_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   acnt_q, acnt_d;
    logic               err_q, err_d;
    logic               enc_vld_q, enc_vld_d;
    logic [31:0]        enc_dat_q, enc_dat_d;

    logic               is_r, is_i, is_j, known;
    logic [5:0]         fn, op;
    logic [31:0]        enc_word;
    logic               enc_legal, zr_reject;

    logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [31:0]        fifo_head;
    logic               push_ok, acc;

    always_comb begin
        is_r  = 1'b0;
        is_i  = 1'b0;
        is_j  = 1'b0;
        known = 1'b1;
        fn    = SLL;
        op    = ZERO;
        case (req_pnem)
            NEM_ZERO:  known = 1'b1;
            NEM_ADD:   begin is_r = 1'b1; fn = ADD;  end
            NEM_AND:   begin is_r = 1'b1; fn = AND;  end
            NEM_OR:    begin is_r = 1'b1; fn = OR;   end
            NEM_SLT:   begin is_r = 1'b1; fn = SLT;  end
            NEM_SUB:   begin is_r = 1'b1; fn = SUB;  end
            NEM_XOR:   begin is_r = 1'b1; fn = XOR;  end
            NEM_SRA:   begin is_r = 1'b1; fn = SRA;  end
            NEM_SRL:   begin is_r = 1'b1; fn = SRL;  end
            NEM_SLL:   begin is_r = 1'b1; fn = SLL;  end
            NEM_MULT:  begin is_r = 1'b1; fn = MULT; end
            NEM_ADDI:  begin is_i = 1'b1; op = ADDI;  end
            NEM_ADDIU: begin is_i = 1'b1; op = ADDIU; end
            NEM_BEQ:   begin is_i = 1'b1; op = BEQ;   end
            NEM_LW:    begin is_i = 1'b1; op = LW;    end
            NEM_SW:    begin is_i = 1'b1; op = SW;    end
            NEM_ABS:   begin is_i = 1'b1; op = ABS;   end
            NEM_JUMP:  is_j  = 1'b1;
            default:   known = 1'b0;
        endcase

        enc_word = 32'h0;
        if (is_r)      enc_word = {ZERO, req_rs, req_rt, req_rd, req_shamt, fn};
        else if (is_i) enc_word = {op, req_rs, req_rt, req_imm};
        else if (is_j) enc_word = {JUMP, req_target};
    end

`ifdef INSTR_ENC_ZEROREG_CHK_EN
    logic sll_nop, i_dst;
    // An all-zero SLL is the canonical NOP, so it must survive the $0 destination check.
    assign sll_nop   = (req_pnem == NEM_SLL) && (req_rs == '0) && (req_rt == '0) &&
                       (req_rd == '0) && (req_shamt == '0);
    assign i_dst     = (req_pnem == NEM_ADDI) || (req_pnem == NEM_ADDIU) ||
                       (req_pnem == NEM_LW)   || (req_pnem == NEM_ABS);
    assign zr_reject = (is_r && (req_rd == '0) && !sll_nop) || (i_dst && (req_rt == '0));
`else
    assign zr_reject = 1'b0;
`endif

    assign enc_legal = known && !zr_reject;

    // The encode register may hold a word while the FIFO is full, giving FIFO_DEPTH+1 slots.
    assign req_ready = (state_q == S_LOAD) && !(enc_vld_q && fifo_full) &&
                       (acnt_q < CNT_W'(MAX_WORDS));
    assign acc       = req_valid && req_ready;
    assign fifo_pop  = !fifo_empty && mem_ready;
    assign push_ok   = !fifo_full || fifo_pop;
    assign fifo_push = enc_vld_q && push_ok;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wcnt_d    = wcnt_q;
        acnt_d    = acnt_q;
        err_d     = err_q;
        enc_vld_d = enc_vld_q;
        enc_dat_d = enc_dat_q;

        if (fifo_push) enc_vld_d = 1'b0;
        if (acc) begin
            enc_vld_d = enc_legal;
            enc_dat_d = enc_word;
            acnt_d    = acnt_q + 1'b1;
            if (!enc_legal) err_d = 1'b1;
        end
        if (fifo_pop) begin
            addr_d = addr_q + ADDR_W'(4);
            wcnt_d = wcnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = base_addr;
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (acc && (last || ((acnt_q + 1'b1) == CNT_W'(MAX_WORDS))))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!enc_vld_q && fifo_empty) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wcnt_q    <= '0;
            acnt_q    <= '0;
            err_q     <= 1'b0;
            enc_vld_q <= 1'b0;
            enc_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wcnt_q    <= wcnt_d;
            acnt_q    <= acnt_d;
            err_q     <= err_d;
            enc_vld_q <= enc_vld_d;
            enc_dat_q <= enc_dat_d;
        end
    end

    isenc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (enc_dat_q),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign mem_we      = !fifo_empty;
    assign mem_addr    = addr_q;
    assign mem_wdata   = fifo_empty ? 32'h0 : fifo_head;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err_illegal = err_q;
    assign word_count  = wcnt_q;
endmodule
